// File: rtl/core_pkg.sv
// Shared types for the vector instruction scoreboard: instruction IDs,
// vector register indices and the per-ID table entry.
package core_pkg;

    localparam int unsigned InsnIDNum   = 8;
    localparam int unsigned InsnIDWidth = $clog2(InsnIDNum);

    typedef logic [InsnIDWidth-1:0] insn_id_t;
    typedef logic [4:0]             vreg_idx_t;

    typedef struct packed {
        logic      valid;
        logic      wr;
        vreg_idx_t vd;
    } sb_entry_t;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW detection of an offered instruction against every
// in-flight entry that writes a vector register.
module sb_hazard_check
    import core_pkg::*;
(
    input  sb_entry_t [InsnIDNum-1:0] entries_i,
    input  vreg_idx_t                 vd_i,
    input  vreg_idx_t                 vs1_i,
    input  vreg_idx_t                 vs2_i,
    input  logic                      wr_vd_i,
    input  logic                      use_vs1_i,
    input  logic                      use_vs2_i,
    output logic                      hazard_o
);

    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned i = 0; i < InsnIDNum; i++) begin
            if (entries_i[i].valid && entries_i[i].wr) begin
                if ((use_vs1_i && (entries_i[i].vd == vs1_i)) ||
                    (use_vs2_i && (entries_i[i].vd == vs2_i)) ||
                    (wr_vd_i   && (entries_i[i].vd == vd_i))) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vinsn_scoreboard.sv
// Vector instruction scoreboard: per-ID in-flight table gating issue on hazards,
// capacity and ID reuse. Define RVV_SB_STALL_CNT_EN to build the stall counter.
module vinsn_scoreboard
    import core_pkg::*;
#(
    parameter  int unsigned MaxInflight = 4,
    localparam int unsigned CntW        = $clog2(MaxInflight + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  insn_id_t        issue_id_i,
    input  vreg_idx_t       issue_vd_i,
    input  vreg_idx_t       issue_vs1_i,
    input  vreg_idx_t       issue_vs2_i,
    input  logic            issue_wr_vd_i,
    input  logic            issue_use_vs1_i,
    input  logic            issue_use_vs2_i,
    input  logic            done_valid_i,
    input  insn_id_t        done_id_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [CntW-1:0] inflight_cnt_o,
    output logic            spurious_done_o,
    output logic [31:0]     stall_cnt_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxInflight);

    sb_entry_t [InsnIDNum-1:0] tbl_q;
    logic [CntW-1:0]           cnt_q;
    logic                      spurious_q;
    logic                      hazard;
    logic                      accept;
    logic                      done_hit;

    sb_hazard_check u_hazard (
        .entries_i (tbl_q),
        .vd_i      (issue_vd_i),
        .vs1_i     (issue_vs1_i),
        .vs2_i     (issue_vs2_i),
        .wr_vd_i   (issue_wr_vd_i),
        .use_vs1_i (issue_use_vs1_i),
        .use_vs2_i (issue_use_vs2_i),
        .hazard_o  (hazard)
    );

    // Only registered state feeds ready, so a same-cycle done never unblocks an issue.
    assign issue_ready_o = !hazard && (cnt_q < MaxCnt) && !tbl_q[issue_id_i].valid && !flush_i;
    assign accept        = issue_valid_i && issue_ready_o;
    assign done_hit      = done_valid_i && tbl_q[done_id_i].valid;

    // accept needs an invalid entry and done_hit a valid one, so they never target the same ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_q      <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else if (flush_i) begin
            tbl_q      <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= done_valid_i && !tbl_q[done_id_i].valid;
            if (done_hit) begin
                tbl_q[done_id_i] <= '0;
            end
            if (accept) begin
                tbl_q[issue_id_i] <= '{valid: 1'b1, wr: issue_wr_vd_i, vd: issue_vd_i};
            end
            if (accept && !done_hit) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!accept && done_hit) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    assign busy_o          = (cnt_q != '0);
    assign inflight_cnt_o  = cnt_q;
    assign spurious_done_o = spurious_q;

`ifdef RVV_SB_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (issue_valid_i && !issue_ready_o && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vinsn_scoreboard.sv
// Scoreboard bench for vinsn_scoreboard: directed scenarios then random traffic,
// checked per cycle against a set-based reference model.
module tb_vinsn_scoreboard;
    import core_pkg::*;

    localparam int MaxInf = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    insn_id_t    issue_id_i = '0;
    vreg_idx_t   issue_vd_i = '0;
    vreg_idx_t   issue_vs1_i = '0;
    vreg_idx_t   issue_vs2_i = '0;
    logic        issue_wr_vd_i = 1'b0;
    logic        issue_use_vs1_i = 1'b0;
    logic        issue_use_vs2_i = 1'b0;
    logic        done_valid_i = 1'b0;
    insn_id_t    done_id_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic [2:0]  inflight_cnt_o;
    logic        spurious_done_o;
    logic [31:0] stall_cnt_o;

    vinsn_scoreboard #(.MaxInflight(MaxInf)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .issue_valid_i   (issue_valid_i),
        .issue_ready_o   (issue_ready_o),
        .issue_id_i      (issue_id_i),
        .issue_vd_i      (issue_vd_i),
        .issue_vs1_i     (issue_vs1_i),
        .issue_vs2_i     (issue_vs2_i),
        .issue_wr_vd_i   (issue_wr_vd_i),
        .issue_use_vs1_i (issue_use_vs1_i),
        .issue_use_vs2_i (issue_use_vs2_i),
        .done_valid_i    (done_valid_i),
        .done_id_i       (done_id_i),
        .flush_i         (flush_i),
        .busy_o          (busy_o),
        .inflight_cnt_o  (inflight_cnt_o),
        .spurious_done_o (spurious_done_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        ready;
        logic [2:0]  cnt;
        logic        busy;
        logic        spur;
        logic [31:0] stall;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: set of in-flight IDs with their destination registers.
    bit       m_valid[InsnIDNum];
    bit       m_wr[InsnIDNum];
    int       m_vd[InsnIDNum];
    bit       m_spur;
    longint   m_stall;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void model_clear();
        foreach (m_valid[i]) begin
            m_valid[i] = 0;
            m_wr[i]    = 0;
            m_vd[i]    = 0;
        end
        m_spur  = 0;
        m_stall = 0;
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (m_valid[i]) n += m_valid[i];
        return n;
    endfunction

    function automatic bit model_ready(int id, int vd, int vs1, int vs2, bit wr, bit u1, bit u2, bit fl);
        bit haz = 0;
        foreach (m_valid[i]) begin
            if (m_valid[i] && m_wr[i] &&
                ((u1 && m_vd[i] == vs1) || (u2 && m_vd[i] == vs2) || (wr && m_vd[i] == vd)))
                haz = 1;
        end
        return !haz && (model_count() < MaxInf) && !m_valid[id] && !fl;
    endfunction

    // One clock of stimulus: drive, push expectations for this cycle, advance the model.
    task automatic drive(input bit v, input int id, input int vd, input int vs1, input int vs2,
                         input bit wr, input bit u1, input bit u2,
                         input bit dv, input int did, input bit fl);
        exp_t e;
        bit   rdy;
        @(posedge clk_i);
        #1;
        cyc++;
        issue_valid_i   = v;
        issue_id_i      = insn_id_t'(id);
        issue_vd_i      = vreg_idx_t'(vd);
        issue_vs1_i     = vreg_idx_t'(vs1);
        issue_vs2_i     = vreg_idx_t'(vs2);
        issue_wr_vd_i   = wr;
        issue_use_vs1_i = u1;
        issue_use_vs2_i = u2;
        done_valid_i    = dv;
        done_id_i       = insn_id_t'(did);
        flush_i         = fl;
        rdy     = model_ready(id, vd, vs1, vs2, wr, u1, u2, fl);
        e.cyc   = cyc;
        e.ready = rdy;
        e.cnt   = 3'(model_count());
        e.busy  = model_count() != 0;
        e.spur  = m_spur;
`ifdef RVV_SB_STALL_CNT_EN
        e.stall = 32'(m_stall);
        if (v && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
`else
        e.stall = 32'd0;
`endif
        exp_q.push_back(e);
        if (fl) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_spur = 0;
        end else begin
            m_spur = dv && !m_valid[did];
            if (dv && m_valid[did]) m_valid[did] = 0;
            if (v && rdy) begin
                m_valid[id] = 1;
                m_wr[id]    = wr;
                m_vd[id]    = vd;
            end
        end
        if (!rst_ni) model_clear();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic done(input int did);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, did, 0);
    endtask

    task automatic issue(input int id, input int vd, input bit wr);
        drive(1, id, vd, 0, 0, wr, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready",    32'(issue_ready_o),   32'(e.ready));
                chk("count",    32'(inflight_cnt_o),  32'(e.cnt));
                chk("busy",     32'(busy_o),          32'(e.busy));
                chk("spurious", 32'(spurious_done_o), 32'(e.spur));
                chk("stall",    stall_cnt_o,          e.stall);
            end
        end
    end

    initial begin : stim
        model_clear();
        repeat (3) idle();
        #3 rst_ni = 1'b1;

        // RAW: id1 reads v3 while id0 writes it; 7 stalled cycles, the last carrying done id0.
        issue(0, 3, 1);
        repeat (6) drive(1, 1, 7, 3, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 7, 3, 0, 0, 1, 0, 1, 0, 0);
        drive(1, 1, 7, 3, 0, 0, 1, 0, 0, 0, 0);
`ifdef RVV_SB_STALL_CNT_EN
        chk("stall_after_raw", stall_cnt_o, 32'd7);
`else
        chk("stall_after_raw", stall_cnt_o, 32'd0);
`endif
        done(1);

        // Capacity: fill to MaxInflight, then one done frees a slot next cycle.
        for (int i = 0; i < 4; i++) issue(i, 10 + i, 1);
        drive(1, 4, 14, 0, 0, 1, 0, 0, 1, 0, 0);
        issue(4, 14, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Simultaneous issue id2 and done id1 at count 2.
        issue(0, 20, 1);
        issue(1, 21, 1);
        drive(1, 2, 22, 0, 0, 1, 0, 0, 1, 1, 0);
        issue(1, 23, 1);
        issue(2, 24, 1);

        // Spurious done on an empty ID, then flush with a done alongside.
        done(5);
        idle();
        idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle();
        idle();

        // Asynchronous reset mid-operation.
        issue(3, 9, 1);
        issue(6, 8, 0);
        #6 rst_ni = 1'b0;
        #1;
        chk("async_rst_count", 32'(inflight_cnt_o), 32'd0);
        chk("async_rst_busy",  32'(busy_o),         32'd0);
        chk("async_rst_stall", stall_cnt_o,         32'd0);
        model_clear();
        repeat (2) idle();
        #3 rst_ni = 1'b1;

        // Random traffic over a small register range so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7),
                  $urandom_range(0, 49) == 0);
        end
        idle();
        @(negedge clk_i);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vinsn_scoreboard.md
VINSN_SCOREBOARD -- requirements
Module: vinsn_scoreboard

Interface
REQ-001 The block SHALL take parameter MaxInflight, default 4, as the maximum number of concurrently in-flight vector instructions (1..InsnIDNum).
REQ-002 The block SHALL have clk_i, input, 1, the single clock.
REQ-003 The block SHALL have rst_ni, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have issue_valid_i, input, 1, a decoded instruction offered by the decoder.
REQ-005 The block SHALL have issue_ready_o, output, 1, which grants the offered instruction to the launcher path.
REQ-006 The block SHALL have issue_id_i, input, insn_id_t, the instruction ID.
REQ-007 The block SHALL have issue_vd_i, issue_vs1_i and issue_vs2_i, input, 5 each, the register specifiers.
REQ-008 The block SHALL have issue_wr_vd_i, issue_use_vs1_i and issue_use_vs2_i, input, 1 each, the operand-use flags.
REQ-009 The block SHALL have done_valid_i, input, 1, and done_id_i, input, insn_id_t, which report completion from the commit path.
REQ-010 The block SHALL have flush_i, input, 1, a scalar-core flush.
REQ-011 The block SHALL have busy_o, output, 1, asserted when any instruction is in flight.
REQ-012 The block SHALL have inflight_cnt_o, output, $clog2(MaxInflight+1), the in-flight count.
REQ-013 The block SHALL have spurious_done_o, output, 1, a one-cycle pulse on a done for an ID that is not in flight.
REQ-014 The block SHALL have stall_cnt_o, output, 32, the stall counter (see Configuration).

Function
REQ-015 The block SHALL keep one table entry per insn_id (InsnIDNum entries), each holding {valid, wr, vd}.
REQ-016 The block SHALL flag a hazard when a valid entry has wr=1 and its vd equals issue_vs1_i (with use_vs1), issue_vs2_i (with use_vs2) or issue_vd_i (with wr_vd); these are the RAW and WAW cases.
REQ-017 issue_ready_o SHALL be combinational and equal: no hazard AND count<MaxInflight AND entry[issue_id_i].valid=0 AND !flush_i.
REQ-018 issue_ready_o SHALL NOT depend on issue_valid_i.
REQ-019 An accept SHALL occur when issue_valid_i && issue_ready_o; the entry becomes {1, wr_vd, vd} in the next cycle and the count increments.
REQ-020 A done with done_valid_i on a valid entry SHALL clear that entry in the next cycle and decrement the count.
REQ-021 A done on an invalid entry SHALL change no state and SHALL pulse spurious_done_o in the next cycle.
REQ-022 Hazard, capacity and ID checks SHALL use registered state only; a same-cycle done SHALL NOT unblock a same-cycle issue.
REQ-023 A simultaneous accept and valid done SHALL leave the count unchanged, and both table updates SHALL be applied.
REQ-024 When flush_i is asserted, all entries and the count SHALL clear in the next cycle, and dones in that cycle SHALL be ignored with no spurious pulse.
REQ-025 The count SHALL never exceed MaxInflight or wrap below 0.
REQ-026 busy_o SHALL equal (count != 0) and SHALL be registered-derived.
REQ-027 There SHALL be no state machine beyond the table; latency from issue to blocking a dependent instruction SHALL be 1 cycle.

Reset
REQ-028 Reset SHALL clear all entries, the count and the stall counter.
REQ-029 During and after reset, spurious_done_o=0, busy_o=0 and inflight_cnt_o=0, and issue_ready_o SHALL follow REQ-017 with an empty table.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tracking immediately and asynchronously.

Configuration
REQ-031 When RVV_SB_STALL_CNT_EN is defined, stall_cnt_o SHALL increment each cycle that issue_valid_i && !issue_ready_o, saturate at 2^32-1, and be cleared by reset only, not by flush.
REQ-032 When RVV_SB_STALL_CNT_EN is undefined, stall_cnt_o SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-033 insn_id_t, InsnIDNum, vreg_idx_t (5 bits) and sb_entry_t SHALL live in core_pkg.
REQ-034 The hazard compare SHALL be a sub-module, sb_hazard_check, that is purely combinational over the entry vector.

Verification
REQ-035 The bench SHALL cover: issue id0 vd=v3 wr=1, then next cycle id1 vs1=v3 -> ready=0 until done id0; ready=1 the cycle after the done.
REQ-036 The bench SHALL cover: MaxInflight=4, 4 independent accepts -> count=4 and ready=0; one done -> count=3 and ready=1 next cycle.
REQ-037 The bench SHALL cover: issue id2 and done id1 in the same cycle at count=2 -> count stays 2, entry1 cleared, entry2 set.
REQ-038 The bench SHALL cover: done id5 with no entry -> spurious_done_o=1 for exactly one cycle and count unchanged.
REQ-039 The bench SHALL cover: 3 in flight, flush_i=1 with a simultaneous done -> count=0, busy_o=0 and no spurious pulse next cycle.
REQ-040 The bench SHALL cover: with RVV_SB_STALL_CNT_EN, a 7-cycle hazard stall -> stall_cnt_o=7; without the macro, stall_cnt_o=0.
